// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Each stage adds one WIDTH/STAGES slice; upper operands skew forward and finished sums deskew alongside.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / 4;
    localparam int L  = STAGES - 1;

    // 4-bit CLA groups; the group P/G terms form the lookahead carry into the next group.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic ci);
        logic [SW-1:0] sum;
        logic [3:0]    p;
        logic [3:0]    g;
        logic          c;
        logic          c1;
        logic          c2;
        logic          c3;
        logic          gp;
        logic          gg;
        c   = ci;
        sum = '0;
        for (int j = 0; j < NG; j++) begin
            p  = x[j*4 +: 4] ^ y[j*4 +: 4];
            g  = x[j*4 +: 4] & y[j*4 +: 4];
            c1 = g[0] | (p[0] & c);
            c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
            gp = &p;
            gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            sum[j*4 +: 4] = p ^ {c3, c2, c1, c};
            c  = gg | (gp & c);
        end
        return {c, sum};
    endfunction

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] en;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;
    logic              neg_q;
    logic              neg_d;

    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [WIDTH-1:0]  src_s;
    logic              src_c;
    logic              src_v;
    logic [SW:0]       slice;
    int                km1;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        c_d    = c_q;
        v_d    = v_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        src_a  = '0;
        src_b  = '0;
        src_s  = '0;
        src_c  = 1'b0;
        src_v  = 1'b0;
        slice  = '0;
        km1    = 0;

        // Load enables ripple back from the output so a full pipe still streams when drained.
        en    = '0;
        en[L] = !v_q[L] || out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end

        for (int k = 0; k < STAGES; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_a = a;
                src_b = sub ? ~b : b;
                src_s = '0;
                src_c = sub | cin;
                src_v = in_valid;
            end else begin
                src_a = a_q[km1];
                src_b = b_q[km1];
                src_s = s_q[km1];
                src_c = c_q[km1];
                src_v = v_q[km1];
            end
            slice = cla_slice(src_a[k*SW +: SW], src_b[k*SW +: SW], src_c);
            if (en[k]) begin
                v_d[k] = src_v;
                // Bubbles leave held data untouched.
                if (src_v) begin
                    a_d[k]            = src_a;
                    b_d[k]            = src_b;
                    s_d[k]            = src_s;
                    s_d[k][k*SW +: SW] = slice[SW-1:0];
                    c_d[k]            = slice[SW];
                end
            end
        end

        if (en[L] && v_d[L]) begin
            zero_d = (s_d[L] == '0);
            neg_d  = s_d[L][WIDTH-1];
            ovf_d  = (a_d[L][WIDTH-1] == b_d[L][WIDTH-1]) && (s_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[L];
    assign s         = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule
